// File: rtl/multdiv_sequencer_pkg.sv
// Shared encodings and defaults for the mult/div sequencer and its watchdog.
package multdiv_sequencer_pkg;

  localparam int unsigned DATA_W                 = 32;
  localparam int unsigned STATE_W                = 3;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 40;
  localparam int unsigned DEFAULT_CNT_W          = 6;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_ISSUE = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DRAIN = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_DONE  = ST_DONE,
    S_DRAIN = ST_DRAIN
  } mdState_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/md_watchdog_counter.sv
// Cycle counter that flags expiry once it reaches LIMIT-1; cleared on issue,
// advanced while the multdiv unit is outstanding.
module md_watchdog_counter #(
  parameter int unsigned CNT_W = 6,
  parameter int unsigned LIMIT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // >= keeps a drain that resumed past the limit from waiting for a wrap
  assign expired_c = (count >= CNT_W'(LIMIT - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences one mult/div operation through the shared iterative unit: latch,
// start pulse, stall until ready or watchdog, one-cycle completion, flush drain.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  input  logic              op_is_div,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              flush,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_ready,
  output logic [DATA_W-1:0] md_a,
  output logic [DATA_W-1:0] md_b,
  output logic              ctrl_mult,
  output logic              ctrl_div,
  output logic              stall,
  output logic              result_valid,
  output logic [DATA_W-1:0] result,
  output logic              exception,
  output logic              timeout,
  output logic              busy
);

  mdState_t          state, stateNext;
  logic              accept, capture, commit;
  logic              wdClear, wdEnable, wdExpired;
  logic              opIsDiv;
  logic [DATA_W-1:0] pendResult, heldResult;
  logic              pendException, heldException;
  logic              pendTimeout, heldTimeout;

  md_watchdog_counter #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .clear     (wdClear),
    .enable    (wdEnable),
    .expired_c (wdExpired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      md_a          <= '0;
      md_b          <= '0;
      opIsDiv       <= OP_MULT;
      pendResult    <= '0;
      pendException <= 1'b0;
      pendTimeout   <= 1'b0;
      heldResult    <= '0;
      heldException <= 1'b0;
      heldTimeout   <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) begin
        md_a    <= operand_a;
        md_b    <= operand_b;
        opIsDiv <= op_is_div;
      end
      // a watchdog completion reports a zero result with exception and timeout
      if (capture) begin
        pendResult    <= md_ready ? md_result : '0;
        pendException <= md_ready ? md_exception : 1'b1;
        pendTimeout   <= ~md_ready;
      end
      if (commit) begin
        heldResult    <= pendResult;
        heldException <= pendException;
        heldTimeout   <= pendTimeout;
      end
    end
  end

  always_comb begin
    stateNext = state;
    stall     = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    commit    = 1'b0;
    wdClear   = 1'b0;
    wdEnable  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (op_valid && !flush) begin
          accept    = 1'b1;
          stall     = 1'b1;
          stateNext = S_ISSUE;
        end
      end
      S_ISSUE: begin
        stall     = 1'b1;
        wdClear   = 1'b1;
        stateNext = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        stall    = 1'b1;
        wdEnable = 1'b1;
        // a flush landing on the completing cycle has nothing left to drain
        if (md_ready || wdExpired) begin
          capture   = !flush;
          stateNext = flush ? S_IDLE : S_DONE;
        end else if (flush) begin
          stateNext = S_DRAIN;
        end
      end
      S_DONE: begin
        commit    = !flush;
        stateNext = S_IDLE;
      end
      S_DRAIN: begin
        stall    = op_valid;
        wdEnable = 1'b1;
        if (md_ready || wdExpired) begin
          stateNext = S_IDLE;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  assign ctrl_mult    = (state == S_ISSUE) && (opIsDiv == OP_MULT);
  assign ctrl_div     = (state == S_ISSUE) && (opIsDiv == OP_DIV);
  assign busy         = (state != S_IDLE);
  assign result_valid = commit;
  assign result       = commit ? pendResult    : heldResult;
  assign exception    = commit ? pendException : heldException;
  assign timeout      = commit ? pendTimeout   : heldTimeout;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer; the bench also plays the multdiv unit,
// answering each start pulse from the operands it sees on md_a/md_b.
module tb_multdiv_sequencer;

  localparam int TIMEOUT = 40;
  localparam int BUDGET  = 80;

  logic        clock, reset, op_valid, op_is_div, flush, md_exception, md_ready;
  logic [31:0] operand_a, operand_b, md_result, md_a, md_b, result;
  logic        ctrl_mult, ctrl_div, stall, result_valid, exception, timeout, busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          doneCyc;
    int          pulseCyc;
    int          multPulses;
    int          divPulses;
    int          stallHigh;
    bit          stallAtDone;
    bit          idleAtStart;
    bit          stable;
    logic [31:0] res;
    logic        exc;
    logic        tmo;
  } obs_t;

  multdiv_sequencer #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (6)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_is_div    (op_is_div),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .flush        (flush),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_ready     (md_ready),
    .md_a         (md_a),
    .md_b         (md_b),
    .ctrl_mult    (ctrl_mult),
    .ctrl_div     (ctrl_div),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result),
    .exception    (exception),
    .timeout      (timeout),
    .busy         (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // What the arithmetic unit computes; divide by zero yields all ones.
  function automatic logic [31:0] ref_calc(input bit isDiv, input logic [31:0] a, input logic [31:0] b);
    if (!isDiv) return a * b;
    if (b == 32'd0) return 32'hFFFF_FFFF;
    return a / b;
  endfunction

  // Every cycle: drive inputs just after the edge, sample 2 time units later.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      op_valid = 1'b0; flush = 1'b0; md_ready = 1'b0;
      #2;
      @(posedge clock); #1;
    end
  endtask

  // Holds op_valid like a stalled execute stage; md_ready comes lat cycles after
  // the start pulse (lat < 0: never). staleKick raises md_ready with junk in cycle 1.
  task automatic run_op(input bit isDiv, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input bit staleKick, output obs_t o);
    int          readyAt;
    bit          divSeen;
    logic [31:0] ua, ub;
    readyAt = -1; divSeen = 1'b0; ua = '0; ub = '0;
    o.doneCyc = -1; o.pulseCyc = -1; o.multPulses = 0; o.divPulses = 0; o.stallHigh = 0;
    o.stallAtDone = 1'b0; o.idleAtStart = 1'b0; o.stable = 1'b1;
    o.res = 'x; o.exc = 1'bx; o.tmo = 1'bx;
    for (int c = 0; c < BUDGET; c++) begin
      op_valid = 1'b1; op_is_div = isDiv; operand_a = a; operand_b = b; flush = 1'b0;
      md_ready = (c == readyAt) || (staleKick && c == 1);
      if (c == readyAt) begin
        md_result    = ref_calc(divSeen, ua, ub);
        md_exception = divSeen && (ub == 32'd0);
      end else begin
        md_result    = $urandom;
        md_exception = 1'($urandom_range(0, 1));
      end
      #2;
      if (c == 0) o.idleAtStart = !busy;
      if (ctrl_mult) o.multPulses++;
      if (ctrl_div)  o.divPulses++;
      if ((ctrl_mult || ctrl_div) && o.pulseCyc < 0) begin
        o.pulseCyc = c; ua = md_a; ub = md_b; divSeen = ctrl_div;
        if (lat > 0) readyAt = c + lat;
      end
      if (o.pulseCyc >= 0 && (md_a !== a || md_b !== b)) o.stable = 1'b0;
      if (result_valid === 1'b1) begin
        o.doneCyc = c; o.stallAtDone = stall; o.res = result; o.exc = exception; o.tmo = timeout;
      end else if (stall === 1'b1) begin
        o.stallHigh++;
      end
      @(posedge clock); #1;
      if (o.doneCyc >= 0) break;
    end
    if (o.doneCyc < 0) begin
      checks++; errors++;
      $display("FAIL op_completion: no result_valid within %0d cycles (a=%h b=%h div=%0d)", BUDGET, a, b, isDiv);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    checks++;
    if ({md_a, md_b, ctrl_mult, ctrl_div, stall, result_valid, result, exception, timeout, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got md_a=%h md_b=%h cm=%b cd=%b st=%b rv=%b res=%h exc=%b to=%b busy=%b, want all 0",
               md_a, md_b, ctrl_mult, ctrl_div, stall, result_valid, result, exception, timeout, busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult_basic();
    obs_t o;
    run_op(1'b0, 32'd6, 32'd7, 32, 1'b0, o);
    idle(1);
    checks++; if (o.pulseCyc !== 1) begin errors++; $display("FAIL mult_pulse_cycle: got %0d want 1", o.pulseCyc); end
    checks++; if (o.multPulses !== 1) begin errors++; $display("FAIL mult_pulse_count: got %0d want 1", o.multPulses); end
    checks++; if (o.divPulses !== 0) begin errors++; $display("FAIL mult_div_pulses: got %0d want 0", o.divPulses); end
    checks++; if (o.doneCyc !== 34) begin errors++; $display("FAIL mult_done_cycle: got %0d want 34", o.doneCyc); end
    checks++; if (o.stallHigh !== 34) begin errors++; $display("FAIL mult_stall_cycles: got %0d want 34", o.stallHigh); end
    checks++; if (o.stallAtDone !== 1'b0) begin errors++; $display("FAIL mult_stall_at_done: got %b want 0", o.stallAtDone); end
    checks++; if (o.res !== 32'd42) begin errors++; $display("FAIL mult_result: got %0d want 42", o.res); end
    checks++; if ({o.exc, o.tmo} !== 2'b00) begin errors++; $display("FAIL mult_exc_tmo: got %b%b want 00", o.exc, o.tmo); end
  endtask

  task automatic test_div_by_zero();
    obs_t o;
    int   lat;
    lat = int'($urandom_range(1, 10));
    run_op(1'b1, 32'd5, 32'd0, lat, 1'b1, o);
    idle(1);
    checks++; if (o.doneCyc !== lat + 2) begin errors++; $display("FAIL div0_done_cycle: got %0d want %0d", o.doneCyc, lat + 2); end
    checks++; if ({o.exc, o.tmo} !== 2'b10) begin errors++; $display("FAIL div0_exc_tmo: got %b%b want 10", o.exc, o.tmo); end
    checks++; if (o.res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_result: got %h want ffffffff", o.res); end
    checks++; if (o.divPulses !== 1 || o.multPulses !== 0) begin errors++; $display("FAIL div0_pulses: got div=%0d mult=%0d want 1/0", o.divPulses, o.multPulses); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_op(1'b0, $urandom, $urandom, -1, 1'b0, o);
    idle(1);
    checks++; if (o.doneCyc !== TIMEOUT + 2) begin errors++; $display("FAIL timeout_done_cycle: got %0d want %0d", o.doneCyc, TIMEOUT + 2); end
    checks++; if (o.res !== 32'd0) begin errors++; $display("FAIL timeout_result: got %h want 0", o.res); end
    checks++; if ({o.exc, o.tmo} !== 2'b11) begin errors++; $display("FAIL timeout_exc_tmo: got %b%b want 11", o.exc, o.tmo); end
    checks++; if (o.stallAtDone !== 1'b0 || o.stallHigh !== TIMEOUT + 2) begin
      errors++; $display("FAIL timeout_stall: got atDone=%b high=%0d want 0/%0d", o.stallAtDone, o.stallHigh, TIMEOUT + 2);
    end
  endtask

  task automatic test_flush_drain();
    obs_t o;
    int   validSeen = 0;
    int   stallBad = 0;
    int   notBusy = 0;
    for (int c = 0; c <= 20; c++) begin
      op_valid  = (c < 8) || (c >= 11);
      op_is_div = (c >= 8);
      operand_a = (c < 8) ? 32'd9 : 32'd100;
      operand_b = (c < 8) ? 32'd9 : 32'd7;
      flush     = (c == 7);
      md_ready  = (c == 20);
      md_result = $urandom; md_exception = 1'b0;
      #2;
      if (result_valid !== 1'b0) validSeen++;
      if (c >= 8 && stall !== op_valid) stallBad++;
      if (c >= 8 && busy !== 1'b1) notBusy++;
      @(posedge clock); #1;
    end
    checks++; if (validSeen !== 0) begin errors++; $display("FAIL flush_no_valid: got %0d strobes want 0", validSeen); end
    checks++; if (stallBad !== 0) begin errors++; $display("FAIL drain_stall_follows_valid: got %0d bad cycles want 0", stallBad); end
    checks++; if (notBusy !== 0) begin errors++; $display("FAIL drain_busy: got %0d idle cycles want 0", notBusy); end
    run_op(1'b1, 32'd100, 32'd7, 3, 1'b0, o);
    idle(1);
    checks++; if (o.idleAtStart !== 1'b1 || o.pulseCyc !== 1) begin
      errors++; $display("FAIL after_drain_accept: got idle=%b pulse=%0d want 1/1", o.idleAtStart, o.pulseCyc);
    end
    checks++; if (o.res !== 32'd14 || o.doneCyc !== 5) begin errors++; $display("FAIL after_drain_result: got %0d@%0d want 14@5", o.res, o.doneCyc); end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    int   l1, l2;
    l1 = int'($urandom_range(1, 8));
    l2 = int'($urandom_range(1, 8));
    run_op(1'b0, 32'd3, 32'd4, l1, 1'($urandom_range(0, 1)), o1);
    run_op(1'b0, 32'd5, 32'd5, l2, 1'b0, o2);
    idle(1);
    checks++; if (o1.res !== 32'd12 || o1.doneCyc !== l1 + 2) begin errors++; $display("FAIL b2b_first: got %0d@%0d want 12@%0d", o1.res, o1.doneCyc, l1 + 2); end
    checks++; if (o2.res !== 32'd25 || o2.doneCyc !== l2 + 2) begin errors++; $display("FAIL b2b_second: got %0d@%0d want 25@%0d", o2.res, o2.doneCyc, l2 + 2); end
    checks++; if (o2.idleAtStart !== 1'b1 || o2.pulseCyc !== 1) begin
      errors++; $display("FAIL b2b_one_idle: got idle=%b pulse=%0d want 1/1", o2.idleAtStart, o2.pulseCyc);
    end
    checks++; if (o1.multPulses + o2.multPulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", o1.multPulses + o2.multPulses); end
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    int   lateSeen = 0;
    for (int c = 0; c <= 5; c++) begin
      op_valid = (c < 5); op_is_div = 1'b0; operand_a = 32'd11; operand_b = 32'd13;
      reset = (c == 5); md_ready = 1'b0;
      #2;
      @(posedge clock); #1;
    end
    reset = 1'b0; op_valid = 1'b0;
    #1;
    checks++;
    if ({md_a, md_b, ctrl_mult, ctrl_div, stall, result_valid, result, exception, timeout, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait: got md_a=%h md_b=%h cm=%b cd=%b st=%b rv=%b res=%h exc=%b to=%b busy=%b, want all 0",
               md_a, md_b, ctrl_mult, ctrl_div, stall, result_valid, result, exception, timeout, busy);
    end
    for (int c = 6; c <= 12; c++) begin
      op_valid = 1'b0; md_ready = (c == 8); md_result = $urandom; md_exception = 1'b1;
      #2;
      if (result_valid !== 1'b0 || busy !== 1'b0) lateSeen++;
      @(posedge clock); #1;
    end
    checks++; if (lateSeen !== 0) begin errors++; $display("FAIL late_ready_ignored: got %0d active cycles want 0", lateSeen); end
    run_op(1'b0, 32'd11, 32'd13, 4, 1'b1, o);
    idle(1);
    checks++; if (o.res !== 32'd143 || o.doneCyc !== 6 || o.pulseCyc !== 1) begin
      errors++; $display("FAIL restart_after_reset: got %0d@%0d pulse %0d want 143@6 pulse 1", o.res, o.doneCyc, o.pulseCyc);
    end
  endtask

  // Model: completion at min(md_ready, watchdog deadline), ready winning a tie.
  task automatic test_random();
    obs_t        o;
    bit          isDiv, expTmo;
    logic [31:0] a, b, expRes;
    int          lat, r, expDone;
    logic        expExc;
    for (int i = 0; i < 20; i++) begin
      isDiv = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      r = int'($urandom_range(0, 9));
      lat = (r == 0) ? -1 : (r == 1) ? int'($urandom_range(38, 44)) : int'($urandom_range(1, 20));
      expTmo  = (lat < 0) || (lat > TIMEOUT);
      expDone = expTmo ? TIMEOUT + 2 : lat + 2;
      expRes  = expTmo ? 32'd0 : ref_calc(isDiv, a, b);
      expExc  = expTmo ? 1'b1 : (isDiv && b == 32'd0);
      run_op(isDiv, a, b, lat, 1'($urandom_range(0, 1)), o);
      checks++; if (o.doneCyc !== expDone) begin errors++; $display("FAIL rnd%0d_done: got %0d want %0d (lat %0d)", i, o.doneCyc, expDone, lat); end
      checks++; if (o.res !== expRes) begin errors++; $display("FAIL rnd%0d_result: got %h want %h", i, o.res, expRes); end
      checks++; if ({o.exc, o.tmo} !== {expExc, expTmo}) begin errors++; $display("FAIL rnd%0d_exc_tmo: got %b%b want %b%b", i, o.exc, o.tmo, expExc, expTmo); end
      checks++; if (o.multPulses !== int'(!isDiv) || o.divPulses !== int'(isDiv)) begin
        errors++; $display("FAIL rnd%0d_pulses: got mult=%0d div=%0d for div=%0d", i, o.multPulses, o.divPulses, isDiv);
      end
      checks++; if (o.stallHigh !== expDone || o.stable !== 1'b1 || o.idleAtStart !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_stall_operands: got stall=%0d stable=%b idle=%b want %0d/1/1", i, o.stallHigh, o.stable, o.idleAtStart, expDone);
      end
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(2);
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_is_div = 1'b0; operand_a = '0; operand_b = '0;
    flush = 1'b0; md_result = '0; md_exception = 1'b0; md_ready = 1'b0;
    test_reset();
    test_mult_basic();
    test_div_by_zero();
    test_timeout();
    test_flush_drain();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
